// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch controller for a 5-stage MIPS pipeline: it selects the comparator
// forwarding paths, stalls on EX producers, resolves beq/bne and keeps branch statistics.
module branch_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             branch_id,
  input  logic             bne_id,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             regwrite_ex,
  input  logic [4:0]       writereg_ex,
  input  logic             regwrite_mem,
  input  logic             memtoreg_mem,
  input  logic [4:0]       writereg_mem,
  input  logic             regwrite_wb,
  input  logic [4:0]       writereg_wb,
  input  logic             branchtaken,
  output logic [1:0]       forwardAD,
  output logic [1:0]       forwardBD,
  output logic             stall_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             pc_src,
  output logic             err_timeout,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_STALL);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_STALL - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_OP = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_next;
  logic              r_err;
  logic              w_err_next;

  logic              w_br;
  logic              w_hazard;
  logic              w_take;
  logic              w_stall;
  logic              w_resolve;

  logic [4:0]        w_src [2];
  logic [1:0]        w_fwd [2];
  logic [2:0]        w_cnt_inc;
  logic [CNT_W-1:0]  w_cnt [3];

  assign w_br     = branch_id | bne_id;
  assign w_take   = branchtaken ^ bne_id;
  assign w_hazard = w_br & regwrite_ex & (writereg_ex != 5'd0) &
                    ((writereg_ex == rs_id) | (writereg_ex == rt_id));

  assign w_src[0] = rs_id;
  assign w_src[1] = rt_id;

  // MEM result wins over WB; r0 is hardwired so it is never forwarded.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign w_fwd[gi] = (w_src[gi] == 5'd0) ? 2'b00 :
                         (regwrite_mem && (writereg_mem == w_src[gi])) ?
                           (memtoreg_mem ? 2'b10 : 2'b01) :
                         (regwrite_wb && (writereg_wb == w_src[gi])) ? 2'b11 : 2'b00;
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait;
    w_err_next   = r_err;
    w_stall      = 1'b0;
    w_resolve    = 1'b0;
    if (!hold) begin
      case (r_state)
        IDLE: begin
          if (w_hazard) begin
            w_stall      = 1'b1;
            w_state_next = WAIT_OP;
            w_wait_next  = '0;
          end else if (w_br) begin
            w_resolve = 1'b1;
          end
        end
        WAIT_OP: begin
          if (!w_br) begin
            w_state_next = IDLE;
            w_wait_next  = '0;
          end else if (w_hazard) begin
            w_stall = 1'b1;
            if (r_wait != WAIT_MAX) begin
              w_wait_next = r_wait + 1'b1;
            end
            if (r_wait >= WAIT_LAST) begin
              w_err_next = 1'b1;
            end
          end else begin
            w_resolve    = 1'b1;
            w_state_next = IDLE;
            w_wait_next  = '0;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_wait_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      r_err   <= w_err_next;
    end
  end

  // Index 0: resolved branches, 1: taken branches, 2: stall cycles.
  assign w_cnt_inc = {w_stall, w_resolve & w_take, w_resolve};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_cnt_inc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  assign forwardAD   = rst ? 2'b00 : w_fwd[0];
  assign forwardBD   = rst ? 2'b00 : w_fwd[1];
  assign stall_ifid  = ~rst & w_stall;
  assign bubble_idex = ~rst & w_stall;
  assign flush_ifid  = ~rst & w_resolve & w_take;
  assign pc_src      = ~rst & w_resolve & w_take;
  assign err_timeout = r_err;
  assign branch_cnt  = w_cnt[0];
  assign taken_cnt   = w_cnt[1];
  assign stall_cnt   = w_cnt[2];

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: hand vector table, multi-cycle corner sequences and
// random stimulus against a cycle-level reference model.
module tb_branch_hazard_ctrl;

  localparam int CNT_W     = 4;
  localparam int MAX_STALL = 4;
  localparam int CMAX      = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       hold;
    logic       b;
    logic       bn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rwe;
    logic [4:0] wre;
    logic       rwm;
    logic       mtm;
    logic [4:0] wrm;
    logic       rww;
    logic [4:0] wrw;
    logic       bt;
  } in_t;

  typedef struct {
    in_t        in;
    logic [7:0] exp;  // {fwdA, fwdB, stall, bubble, flush, pc_src}
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  in_t              cur;
  logic [1:0]       forwardAD, forwardBD;
  logic             stall_ifid, bubble_idex, flush_ifid, pc_src, err_timeout;
  logic [CNT_W-1:0] branch_cnt, taken_cnt, stall_cnt;

  branch_hazard_ctrl #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (cur.hold),
    .branch_id    (cur.b),
    .bne_id       (cur.bn),
    .rs_id        (cur.rs),
    .rt_id        (cur.rt),
    .regwrite_ex  (cur.rwe),
    .writereg_ex  (cur.wre),
    .regwrite_mem (cur.rwm),
    .memtoreg_mem (cur.mtm),
    .writereg_mem (cur.wrm),
    .regwrite_wb  (cur.rww),
    .writereg_wb  (cur.wrw),
    .branchtaken  (cur.bt),
    .forwardAD    (forwardAD),
    .forwardBD    (forwardBD),
    .stall_ifid   (stall_ifid),
    .bubble_idex  (bubble_idex),
    .flush_ifid   (flush_ifid),
    .pc_src       (pc_src),
    .err_timeout  (err_timeout),
    .branch_cnt   (branch_cnt),
    .taken_cnt    (taken_cnt),
    .stall_cnt    (stall_cnt)
  );

  int   errors = 0;
  int   checks = 0;
  // Reference model: counters as plain integers, plus the length of the current
  // run of stall cycles spent on one branch.
  int   m_bc = 0, m_tc = 0, m_sc = 0, m_streak = 0;
  logic m_err = 1'b0;

  function automatic in_t mk(input logic h, input logic b, input logic bn,
                             input int rs, input int rt, input logic rwe, input int wre,
                             input logic rwm, input logic mtm, input int wrm,
                             input logic rww, input int wrw, input logic bt);
    in_t v;
    v.hold = h;   v.b = b;     v.bn = bn;
    v.rs = 5'(rs); v.rt = 5'(rt);
    v.rwe = rwe;  v.wre = 5'(wre);
    v.rwm = rwm;  v.mtm = mtm; v.wrm = 5'(wrm);
    v.rww = rww;  v.wrw = 5'(wrw);
    v.bt = bt;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] x, input in_t v);
    if (x == 5'd0) return 2'b00;
    if (v.rwm && v.wrm == x) return v.mtm ? 2'b10 : 2'b01;
    if (v.rww && v.wrw == x) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit m_hazard(input in_t v);
    return (v.b || v.bn) && v.rwe && (v.wre != 5'd0) && (v.wre == v.rs || v.wre == v.rt);
  endfunction

  function automatic logic [7:0] model_comb(input in_t v, input logic r);
    bit   active, br, stall, resolve, take;
    active  = !r && !v.hold;
    br      = v.b || v.bn;
    take    = v.bt ^ v.bn;
    stall   = active && br && m_hazard(v);
    resolve = active && br && !m_hazard(v);
    if (r) return 8'h00;
    return {m_fwd(v.rs, v), m_fwd(v.rt, v), stall, stall, resolve && take, resolve && take};
  endfunction

  task automatic model_update(input in_t v, input logic r);
    bit br;
    br = v.b || v.bn;
    if (r) begin
      m_bc = 0; m_tc = 0; m_sc = 0; m_streak = 0; m_err = 1'b0;
    end else if (!v.hold) begin
      if (br && m_hazard(v)) begin
        if (m_sc < CMAX) m_sc++;
        m_streak++;
        if (m_streak > MAX_STALL) m_err = 1'b1;
      end else if (br) begin
        if (m_bc < CMAX) m_bc++;
        if ((v.bt ^ v.bn) && m_tc < CMAX) m_tc++;
        m_streak = 0;
      end else begin
        m_streak = 0;
      end
    end
  endtask

  // Called 1 time unit after a rising edge; returns at the same point one cycle later.
  task automatic step(input string name, input in_t v, input bit has_exp, input logic [7:0] exp);
    logic [7:0]  act;
    logic [12:0] post_act, post_exp;
    cur = v;
    #4;
    act = {forwardAD, forwardBD, stall_ifid, bubble_idex, flush_ifid, pc_src};
    chk({name, "/comb"}, int'(act), int'(model_comb(v, rst)));
    if (has_exp) chk({name, "/vec"}, int'(act), int'(exp));
    @(posedge clk);
    model_update(v, rst);
    #1;
    post_act = {err_timeout, branch_cnt, taken_cnt, stall_cnt};
    post_exp = {m_err, 4'(m_bc), 4'(m_tc), 4'(m_sc)};
    chk({name, "/state"}, int'(post_act), int'(post_exp));
    $display("%-12s rst=%0b fA=%0d fB=%0d st=%0b fl=%0b pc=%0b err=%0b bc=%0d tc=%0d sc=%0d",
             name, rst, act[7:6], act[5:4], act[3], act[1], act[0],
             err_timeout, branch_cnt, taken_cnt, stall_cnt);
  endtask

  vec_t tbl [8];
  in_t  haz;
  in_t  v;

  initial begin
    tbl[0] = '{mk(0,1,0, 3,4, 0,0, 1,0,3, 1,4, 1), 8'b01_11_0_0_1_1};
    tbl[1] = '{mk(0,0,1, 2,2, 0,0, 0,0,0, 0,0, 1), 8'b00_00_0_0_0_0};
    tbl[2] = '{mk(0,1,0, 0,0, 1,0, 1,0,0, 0,0, 1), 8'b00_00_0_0_1_1};
    tbl[3] = '{mk(0,0,0, 7,1, 0,0, 1,1,7, 0,0, 0), 8'b10_00_0_0_0_0};
    tbl[4] = '{mk(0,1,0, 9,9, 0,0, 1,0,9, 1,9, 0), 8'b01_01_0_0_0_0};
    tbl[5] = '{mk(0,0,1, 6,2, 0,0, 0,0,6, 1,6, 0), 8'b11_00_0_0_1_1};
    tbl[6] = '{mk(1,1,0, 3,4, 0,0, 1,0,3, 0,0, 1), 8'b01_00_0_0_0_0};
    tbl[7] = '{mk(0,0,0, 3,4, 1,3, 0,0,0, 0,0, 0), 8'b00_00_0_0_0_0};

    rst = 1'b1;
    cur = '0;
    @(posedge clk);
    #1;
    step("reset0", mk(0,1,0, 3,4, 0,0, 1,0,3, 1,4, 1), 1'b1, 8'h00);
    step("reset1", mk(0,1,0, 3,4, 1,3, 1,1,4, 0,0, 1), 1'b1, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) step($sformatf("vec%0d", i), tbl[i].in, 1'b1, tbl[i].exp);
    chk("tbl_branch_cnt", int'(branch_cnt), 5);
    chk("tbl_taken_cnt",  int'(taken_cnt), 3);
    chk("tbl_stall_cnt",  int'(stall_cnt), 0);

    // Load in EX feeding rs: one stall, then forwarded from data_out.
    step("lw_stall",   mk(0,1,0, 5,0, 1,5, 0,0,0, 0,0, 0), 1'b1, 8'b00_00_1_1_0_0);
    step("lw_resolve", mk(0,1,0, 5,0, 0,0, 1,1,5, 0,0, 1), 1'b1, 8'b10_00_0_0_1_1);
    chk("lw_counts", int'({branch_cnt, taken_cnt, stall_cnt}), int'({4'd6, 4'd4, 4'd1}));

    // ALU producer in EX feeding rt of a bne: one stall, then forwarded from EX/MEM.
    step("alu_stall",   mk(0,0,1, 1,8, 1,8, 0,0,0, 0,0, 0), 1'b1, 8'b00_00_1_1_0_0);
    step("alu_resolve", mk(0,0,1, 1,8, 0,0, 1,0,8, 0,0, 0), 1'b1, 8'b00_01_0_0_1_1);

    haz = mk(0,1,0, 4,9, 1,4, 0,0,0, 0,0, 0);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("timeout%0d", i), haz, 1'b1, 8'b00_00_1_1_0_0);
      chk($sformatf("timeout_err%0d", i), int'(err_timeout), (i == 4) ? 1 : 0);
    end
    chk("timeout_sc", int'(stall_cnt), 7);
    v = haz;
    v.hold = 1'b1;
    step("hold_stall", v, 1'b1, 8'h00);
    chk("hold_sc_frozen", int'(stall_cnt), 7);

    rst = 1'b1;
    step("rst_wait", haz, 1'b1, 8'h00);
    rst = 1'b0;
    chk("rst_err", int'(err_timeout), 0);
    chk("rst_counts", int'({branch_cnt, taken_cnt, stall_cnt}), 0);
    for (int i = 0; i < 4; i++) step($sformatf("post_rst%0d", i), haz, 1'b0, 8'h00);
    chk("post_rst_err", int'(err_timeout), 0);
    step("post_rst_res", mk(0,1,0, 4,9, 0,0, 0,0,0, 0,0, 1), 1'b1, 8'b00_00_0_0_1_1);
    chk("post_rst_bc", int'(branch_cnt), 1);

    rst = 1'b1;
    step("rst_sat", haz, 1'b0, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      step($sformatf("sat%0d", i), mk(0,1,0, 1,2, 0,0, 0,0,0, 0,0, 1), 1'b0, 8'h00);
      chk($sformatf("sat_bc%0d", i), int'(branch_cnt), (i + 1 > CMAX) ? CMAX : i + 1);
    end

    for (int n = 0; n < 400; n++) begin
      v = '0;
      rst    = ($urandom_range(0, 49) == 0);
      v.hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) v.b = 1'b1;
        else v.bn = 1'b1;
      end
      v.rs  = 5'($urandom_range(0, 3));
      v.rt  = 5'($urandom_range(0, 3));
      v.rwe = 1'($urandom_range(0, 1));
      v.wre = 5'($urandom_range(0, 3));
      v.rwm = 1'($urandom_range(0, 1));
      v.mtm = 1'($urandom_range(0, 1));
      v.wrm = 5'($urandom_range(0, 3));
      v.rww = 1'($urandom_range(0, 1));
      v.wrw = 5'($urandom_range(0, 3));
      v.bt  = 1'($urandom_range(0, 1));
      step($sformatf("rnd%0d", n), v, 1'b0, 8'h00);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
